// File: rtl/kw_space_scanner.sv
// Keyword/whitespace scanner: recognises a fixed SystemVerilog keyword set in a
// char stream, counts the space/tab run after each keyword and emits one event per keyword.
module kw_space_scanner #(
  parameter int MAX_WORD = 12,
  parameter int SPW      = 4,
  parameter int LW       = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [7:0]     in_char,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2:0]     out_kw,
  output logic [SPW-1:0] out_spaces,
  output logic [LW-1:0]  out_line,
  output logic           out_violation
);

  localparam int LENW = $clog2(MAX_WORD + 1);
  localparam int WBW  = 8 * MAX_WORD;

  typedef enum logic [2:0] {S_IDLE, S_SLASH, S_COMMENT, S_WORD, S_SPACE} state_e;

  state_e           state_q, state_d;
  logic [WBW-1:0]   word_q, word_d;
  logic [LENW-1:0]  len_q, len_d;
  logic             ovf_q, ovf_d;
  logic [2:0]       kw_q, kw_d;
  logic [SPW-1:0]   cnt_q, cnt_d;
  logic [LW-1:0]    wline_q, wline_d;
  logic [LW-1:0]    line_q, line_d;

  logic             out_valid_q;
  logic [2:0]       out_kw_q;
  logic [SPW-1:0]   out_spaces_q;
  logic [LW-1:0]    out_line_q;
  logic             out_viol_q;

  logic             accept, is_ident, is_ws, is_nl, is_slash;
  logic             emit, go_idle;
  logic [2:0]       emit_kw, kw_hit;
  logic [SPW-1:0]   emit_cnt;

  // The buffer is a shift register, newest char in the low byte, so a word of
  // length n is compared against its low 8*n bits.
  function automatic logic [2:0] kw_lookup(input logic [WBW-1:0] w, input logic [LENW-1:0] n);
    kw_lookup = 3'd0;
    if (n == LENW'(6) && w[47:0] == "module")    kw_lookup = 3'd1;
    if (n == LENW'(3) && w[23:0] == "for")       kw_lookup = 3'd2;
    if (n == LENW'(6) && w[47:0] == "assign")    kw_lookup = 3'd3;
    if (n == LENW'(9) && w[71:0] == "always_ff") kw_lookup = 3'd4;
    if (n == LENW'(2) && w[15:0] == "if")        kw_lookup = 3'd5;
    if (n == LENW'(4) && w[31:0] == "case")      kw_lookup = 3'd6;
    if (n == LENW'(4) && w[31:0] == "else")      kw_lookup = 3'd7;
  endfunction

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign is_ident = (in_char >= "a" && in_char <= "z") || (in_char >= "A" && in_char <= "Z") ||
                    (in_char >= "0" && in_char <= "9") || in_char == "_" || in_char == "$";
  assign is_ws    = in_char == 8'h20 || in_char == 8'h09 || in_char == 8'h0D;
  assign is_nl    = in_char == 8'h0A;
  assign is_slash = in_char == "/";
  assign kw_hit   = ovf_q ? 3'd0 : kw_lookup(word_q, len_q);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    len_d    = len_q;
    ovf_d    = ovf_q;
    kw_d     = kw_q;
    cnt_d    = cnt_q;
    wline_d  = wline_q;
    line_d   = line_q;
    emit     = 1'b0;
    emit_kw  = kw_q;
    emit_cnt = cnt_q;
    go_idle  = 1'b0;
    if (accept) begin
      if (is_nl && line_q != '1) line_d = line_q + LW'(1);
      unique case (state_q)
        S_IDLE:    go_idle = 1'b1;
        S_SLASH:   if (is_slash) state_d = S_COMMENT; else go_idle = 1'b1;
        S_COMMENT: if (is_nl) state_d = S_IDLE;
        S_WORD: begin
          if (is_ident) begin
            word_d = {word_q[WBW-9:0], in_char};
            if (len_q == LENW'(MAX_WORD)) ovf_d = 1'b1;
            else                          len_d = len_q + LENW'(1);
          end else if (kw_hit == 3'd0) begin
            go_idle = 1'b1;
          end else if (is_ws) begin
            state_d = S_SPACE;
            kw_d    = kw_hit;
            cnt_d   = SPW'(1);
          end else begin
            emit     = 1'b1;
            emit_kw  = kw_hit;
            emit_cnt = '0;
            if (is_nl) state_d = S_IDLE; else go_idle = 1'b1;
          end
        end
        S_SPACE: begin
          if (is_ws) begin
            if (cnt_q != '1) cnt_d = cnt_q + SPW'(1);
          end else begin
            emit = 1'b1;
            if (is_nl) state_d = S_IDLE; else go_idle = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
      // Terminating chars fall through to the idle-state rules in the same cycle.
      if (go_idle) begin
        if (is_ident) begin
          state_d = S_WORD;
          word_d  = {{(WBW-8){1'b0}}, in_char};
          len_d   = LENW'(1);
          ovf_d   = 1'b0;
          wline_d = line_q;
        end else if (is_slash) begin
          state_d = S_SLASH;
        end else begin
          state_d = S_IDLE;
        end
      end
    end
  end

  // NOTE: the word buffer is reset too, so a reset mid-word leaves no stale chars behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      word_q       <= '0;
      len_q        <= '0;
      ovf_q        <= 1'b0;
      kw_q         <= '0;
      cnt_q        <= '0;
      wline_q      <= LW'(1);
      line_q       <= LW'(1);
      out_valid_q  <= 1'b0;
      out_kw_q     <= '0;
      out_spaces_q <= '0;
      out_line_q   <= '0;
      out_viol_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      kw_q    <= kw_d;
      cnt_q   <= cnt_d;
      wline_q <= wline_d;
      line_q  <= line_d;
      if (emit) begin
        out_valid_q  <= 1'b1;
        out_kw_q     <= emit_kw;
        out_spaces_q <= emit_cnt;
        out_line_q   <= wline_q;
        out_viol_q   <= emit_cnt != SPW'(1);
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid     = out_valid_q;
  assign out_kw        = out_kw_q;
  assign out_spaces    = out_spaces_q;
  assign out_line      = out_line_q;
  assign out_violation = out_viol_q;

endmodule

// File: tb/tb_kw_space_scanner.sv
// Bench for kw_space_scanner: directed scenarios plus random text compared
// against a string-level tokenizer model of the keyword/spacing rules.
module tb_kw_space_scanner;

  typedef struct {
    int kw;
    int sp;
    int line;
    int viol;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_char = 8'h00;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [2:0]  out_kw;
  logic [3:0]  out_spaces;
  logic [15:0] out_line;
  logic        out_violation;

  int  n_cmp = 0;
  int  n_fail = 0;
  bit  rnd_mode = 1'b0;
  ev_t got_q[$];
  ev_t exp_q[$];

  kw_space_scanner #(.MAX_WORD(12), .SPW(4), .LW(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_kw(out_kw), .out_spaces(out_spaces), .out_line(out_line),
    .out_violation(out_violation)
  );

  always #5 clk = ~clk;

  // Events are recorded on the cycle they are popped.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready)
      got_q.push_back('{int'(out_kw), int'(out_spaces), int'(out_line), int'(out_violation)});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk); #1;
    if (rnd_mode) out_ready = ($urandom_range(9) < 7);
  endtask

  task automatic send_char(input byte c);
    int budget;
    bit acc;
    if (rnd_mode) while ($urandom_range(3) == 0) cycle();
    in_valid = 1'b1;
    in_char  = c;
    budget   = 0;
    acc      = 1'b0;
    while (!acc && budget < 1000) begin
      @(negedge clk);
      acc = in_ready;
      cycle();
      budget++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_fail++;
      $error("FAIL accept_timeout: observed no accept expected accept of char %0d", c);
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic drain();
    rnd_mode  = 1'b0;
    out_ready = 1'b1;
    repeat (4) cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    got_q.delete();
  endtask

  task automatic expect_ev(input string tag, input int idx, input int kw, input int sp, input int ln);
    if (idx < got_q.size()) begin
      check({tag, ".kw"},   got_q[idx].kw,   kw);
      check({tag, ".sp"},   got_q[idx].sp,   sp);
      check({tag, ".line"}, got_q[idx].line, ln);
      check({tag, ".viol"}, got_q[idx].viol, (sp != 1) ? 1 : 0);
    end else begin
      n_cmp++;
      n_fail++;
      $error("FAIL %s: observed no event expected kw %0d", tag, kw);
    end
  endtask

  // ---------------- reference model: tokenizer over the whole text ----------------
  function automatic bit m_ident(input byte c);
    return (c >= "a" && c <= "z") || (c >= "A" && c <= "Z") || (c >= "0" && c <= "9") ||
           c == "_" || c == "$";
  endfunction

  function automatic bit m_ws(input byte c);
    return c == 8'h20 || c == 8'h09 || c == 8'h0D;
  endfunction

  function automatic int m_kw(input string w);
    case (w)
      "module":    return 1;
      "for":       return 2;
      "assign":    return 3;
      "always_ff": return 4;
      "if":        return 5;
      "case":      return 6;
      "else":      return 7;
      default:     return 0;
    endcase
  endfunction

  // An event exists once some non-whitespace char follows the keyword's space run.
  function automatic void build_model(input string s);
    int i, j, k, n, id, line, sp;
    exp_q.delete();
    n = s.len();
    i = 0;
    line = 1;
    while (i < n) begin
      if (s[i] == "/" && i + 1 < n && s[i+1] == "/") begin
        while (i < n && s[i] != 8'h0A) i++;
      end else if (s[i] == 8'h0A) begin
        line++;
        i++;
      end else if (m_ident(s[i])) begin
        j = i;
        while (j < n && m_ident(s[j])) j++;
        id = m_kw(s.substr(i, j - 1));
        if (id != 0) begin
          k = j;
          while (k < n && m_ws(s[k])) k++;
          sp = (k - j > 15) ? 15 : k - j;
          if (k < n) exp_q.push_back('{id, sp, line, (sp != 1) ? 1 : 0});
        end
        i = j;
      end else begin
        i++;
      end
    end
  endfunction

  string toks[$] = '{"module", "for", "assign", "always_ff", "if", "case", "else", "iff",
                     "modules", "endcase", "always_ffx", "fo", "x", "abc_12", "$d", "Module",
                     "averyveryverylongident", " ", "  ", "\t", "\r", "\n", "(", ";", "@",
                     "/", "//", "// if case\n", "     ", "a"};

  initial begin
    string s;
    int nmin;

    // Reset values
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst.out_valid", out_valid, 0);
    check("rst.out_kw", out_kw, 0);
    check("rst.out_spaces", out_spaces, 0);
    check("rst.out_line", out_line, 0);
    check("rst.out_violation", out_violation, 0);
    check("rst.in_ready", in_ready, 1);
    rst = 1'b0;

    // Double space after module
    do_reset();
    send_str("module  M;\n");
    drain();
    check("t1.count", got_q.size(), 1);
    expect_ev("t1.e0", 0, 1, 2, 1);

    // Keywords terminated by punctuation, across lines
    do_reset();
    send_str("  for(genvar i\n  always_ff@(posedge clk)\n");
    drain();
    check("t2.count", got_q.size(), 2);
    expect_ev("t2.e0", 0, 2, 0, 1);
    expect_ev("t2.e1", 1, 4, 0, 2);

    // Keyword inside a comment is ignored
    do_reset();
    send_str("if (a) x; // if  (b)\ncase(a)\n");
    drain();
    check("t3.count", got_q.size(), 2);
    expect_ev("t3.e0", 0, 5, 1, 1);
    expect_ev("t3.e1", 1, 6, 0, 2);

    // Space count saturation
    do_reset();
    s = "assign";
    for (int i = 0; i < 20; i++) s = {s, " "};
    send_str({s, "a"});
    drain();
    check("t4.count", got_q.size(), 1);
    expect_ev("t4.sat", 0, 3, 15, 1);

    // Newline terminator gives zero spaces
    do_reset();
    send_str("assign\n");
    drain();
    check("t5.count", got_q.size(), 1);
    expect_ev("t5.nl", 0, 3, 0, 1);

    // Superset words never match
    do_reset();
    send_str("iff modules endcase ");
    drain();
    check("t6.count", got_q.size(), 0);

    // Backpressure: first event held stable, input stalled
    do_reset();
    out_ready = 1'b0;
    send_str("if  (");
    in_valid = 1'b1;
    in_char  = "a";
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t7.hold.valid", out_valid, 1);
      check("t7.hold.kw", out_kw, 5);
      check("t7.hold.sp", out_spaces, 2);
      check("t7.hold.in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_str("a) else x");
    drain();
    check("t7.count", got_q.size(), 2);
    expect_ev("t7.e0", 0, 5, 2, 1);
    expect_ev("t7.e1", 1, 7, 1, 1);

    // Reset in the middle of a word, after the line counter has advanced
    do_reset();
    send_str("\n\nmodu");
    rst = 1'b1;
    @(posedge clk); #1;
    check("t8.rst.out_valid", out_valid, 0);
    check("t8.rst.out_line", out_line, 0);
    rst = 1'b0;
    send_str("le M;");
    drain();
    check("t8.tail.count", got_q.size(), 0);
    send_str("module M");
    drain();
    check("t8.fresh.count", got_q.size(), 1);
    expect_ev("t8.fresh", 0, 1, 1, 1);

    // Random text with random stalls, against the model
    for (int r = 0; r < 6; r++) begin
      do_reset();
      s = "";
      for (int t = 0; t < 120; t++) s = {s, toks[$urandom_range(toks.size() - 1)]};
      build_model(s);
      rnd_mode = 1'b1;
      send_str(s);
      drain();
      check($sformatf("rnd%0d.count", r), got_q.size(), exp_q.size());
      nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int e = 0; e < nmin; e++) begin
        check($sformatf("rnd%0d.e%0d.kw", r, e),   got_q[e].kw,   exp_q[e].kw);
        check($sformatf("rnd%0d.e%0d.sp", r, e),   got_q[e].sp,   exp_q[e].sp);
        check($sformatf("rnd%0d.e%0d.line", r, e), got_q[e].line, exp_q[e].line);
        check($sformatf("rnd%0d.e%0d.viol", r, e), got_q[e].viol, exp_q[e].viol);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/kw_space_scanner.md
Name: kw_space_scanner

Overview:
- Streaming front-end stage that scans an ASCII source-text byte stream and recognises a fixed set of SystemVerilog keywords.
- For each keyword it counts the whitespace characters that follow it.
- It emits one event per keyword to the downstream style-rule checker, which flags spacing violations.
- Comments (`//` to end of line) are skipped. Line numbers are tracked for reporting.

Parameters:
- MAX_WORD, 12, identifier buffer depth in chars; must be >= 9.
- SPW, 4, width of the space count; the count saturates at 2^SPW-1.
- LW, 16, width of the line counter; the counter saturates at 2^LW-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input char valid.
- in_ready  out  1  input char accepted when in_valid && in_ready.
- in_char  in  8  ASCII character.
- out_valid  out  1  keyword event valid.
- out_ready  in  1  downstream accepts the event.
- out_kw  out  3  keyword id: 1 module, 2 for, 3 assign, 4 always_ff, 5 if, 6 case, 7 else; 0 is never emitted.
- out_spaces  out  SPW  count of space/tab chars after the keyword (saturating).
- out_line  out  LW  line on which the keyword started (first line = 1).
- out_violation  out  1  out_spaces != 1.

Behaviour:
- Single clock clk; rst is synchronous, active-high. All state is updated only on accepted chars or output pops.
- Reset values:
  - out_valid=0; out_kw, out_spaces, out_violation = 0; out_line=0.
  - line counter = 1; state = IDLE; word buffer cleared.
- Reset mid-operation discards any partial word, count or pending event.
- in_ready = !out_valid || out_ready (combinational). The scanner stalls entirely while an event is pending and not popped.
- Output register:
  - Loaded on the cycle the terminating char is accepted, so latency is 1 cycle from that char to out_valid.
  - out_valid holds and the fields stay stable until out_valid && out_ready.
  - A pop and a new load in the same cycle are legal; the new event wins.
- Char classes:
  - ident = [A-Za-z0-9_$].
  - ws = 0x20 or 0x09.
  - nl = 0x0A.
  - 0x0D is treated as ws.
- Line counter increments on every accepted nl, in any state.
- States:
  - IDLE:
    - ident -> WORD; store the char; capture the line.
    - '/' -> SLASH.
    - Anything else -> IDLE.
  - SLASH:
    - '/' -> COMMENT.
    - Otherwise the char is processed exactly as in IDLE, in the same cycle.
  - COMMENT: nl -> IDLE; everything else is ignored. Keywords inside comments produce no event.
  - WORD:
    - ident: append; on length > MAX_WORD, set an overflow flag (an overflowed word never matches).
    - Non-ident terminates the word, which is compared exactly and case-sensitively against the keyword set.
    - No match: process the terminating char as IDLE.
    - Match, terminator ws: -> SPACE with count=1.
    - Match, terminator nl: emit immediately, spaces=0, state IDLE.
    - Match, other terminator: emit immediately, spaces=0, and process that char as IDLE (e.g. '(' '@' ';', or '/' -> SLASH).
  - SPACE:
    - ws: count+1, saturating.
    - nl: emit with the current count -> IDLE.
    - Any other char: emit with the current count, and process the char as IDLE in the same cycle (e.g. it may start a new WORD).
- Prefix and superset words do not match (e.g. "iff", "modules", "always_ffx", "endcase").
- An event carries the line of the keyword's first char, not the terminator's line.

Test Plan:
- Stream "module  M;\n" with out_ready=1 -> one event: kw=1, spaces=2, line=1, violation=1.
- Stream "  for(genvar i\n  always_ff@(posedge clk)\n" -> events (kw=2, spaces=0, line=1, viol=1) then (kw=4, spaces=0, line=2, viol=1). "genvar", "posedge" and "clk" produce no events.
- Stream "if (a) x; // if  (b)\ncase(a)\n" -> (kw=5, spaces=1, line=1, viol=0) then (kw=6, spaces=0, line=2, viol=1). The commented "if" produces no event.
- Stream "assign" + 20 spaces + "a" -> kw=3, spaces=15 (saturated), viol=1. Also "assign\n" -> kw=3, spaces=0. Also "iff modules endcase " -> no events.
- Backpressure: hold out_ready=0 while streaming "if  (a) else x" -> first event (kw=5, spaces=2) stays stable and in_ready=0. Release out_ready -> event popped, scanning resumes, then (kw=7, spaces=1). No chars are lost or duplicated.
- Assert rst while in WORD after "modu" -> next cycle out_valid=0, line=1. Streaming "le M" then emits nothing. A fresh "module M" emits kw=1, spaces=1, line=1.
